// File: rtl/ctrl_pkg.sv
// Shared types and constants for the multicycle RV32 control sequencer.
// Contents: state encoding, opcode constants, ALU op classes, datapath mux selects, trap causes.
// Used by: multicycle_control, ctrl_wait_timer.
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic       ADR_PC     = 1'b0;
    localparam logic       ADR_ALUOUT = 1'b1;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_RDATA     = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_BUS     = 2'b10;

    // States that hold a memory request open and wait on mem_ready.
    function automatic logic is_wait_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEMREAD) || (s == S_MEMWRITE);
    endfunction

endpackage

// File: rtl/ctrl_wait_timer.sv
// Memory wait watchdog: counts consecutive stalled cycles in a memory state.
// Ports: clk/rst_n, active (in a wait state), mem_ready; timeout is combinational,
//        high in the stalled cycle that would be the WAIT_LIMIT-th in a row.
module ctrl_wait_timer
    import ctrl_pkg::*;
#(
    parameter int unsigned WAIT_LIMIT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic active,
    input  logic mem_ready,
    output logic timeout
);

    localparam logic [7:0] LAST = 8'(WAIT_LIMIT - 1);

    logic [7:0] cnt;
    logic       stalled;

    assign stalled = active && !mem_ready;
    assign timeout = stalled && (cnt == LAST);

    // The sequencer only stays in its state while stalled without a timeout;
    // every other case is either a completed access or a state change, both
    // of which restart the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (stalled && !timeout) begin
            cnt <= cnt + 8'd1;
        end else begin
            cnt <= '0;
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// Main sequencer of the multicycle RV32 core: fetch/decode/execute/writeback FSM.
// Ports: opcode/zero/mem_ready/trap_clear in; datapath enables, mux selects, alu_op,
//        trap/trap_cause and state_dbg out (Moore decode, gated by mem_ready/zero).
module multicycle_control
    import ctrl_pkg::*;
#(
    parameter int unsigned WAIT_LIMIT = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    input  logic       trap_clear,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       reg_write,
    output logic       trap,
    output logic [1:0] trap_cause,
    output logic [3:0] state_dbg
);

    state_t     state, state_next;
    logic [1:0] cause_q, cause_next;
    logic       timeout;

    ctrl_wait_timer #(.WAIT_LIMIT(WAIT_LIMIT)) u_wait_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .active    (is_wait_state(state)),
        .mem_ready (mem_ready),
        .timeout   (timeout)
    );

    // State register (trap cause travels with it).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_FETCH;
            cause_q <= CAUSE_NONE;
        end else begin
            state   <= state_next;
            cause_q <= cause_next;
        end
    end

    // Next-state logic. A completed access takes priority over the timeout.
    always_comb begin
        state_next = state;
        cause_next = cause_q;
        case (state)
            S_FETCH: begin
                if (mem_ready) begin
                    state_next = S_DECODE;
                end else if (timeout) begin
                    state_next = S_TRAP;
                    cause_next = CAUSE_BUS;
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: state_next = S_MEMADR;
                    OP_RTYPE:          state_next = S_EXECR;
                    OP_ITYPE:          state_next = S_EXECI;
                    OP_BRANCH:         state_next = S_BEQ;
                    OP_JAL:            state_next = S_JAL;
                    default: begin
                        state_next = S_TRAP;
                        cause_next = CAUSE_ILLEGAL;
                    end
                endcase
            end
            S_MEMADR:  state_next = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD: begin
                if (mem_ready) begin
                    state_next = S_MEMWB;
                end else if (timeout) begin
                    state_next = S_TRAP;
                    cause_next = CAUSE_BUS;
                end
            end
            S_MEMWB:   state_next = S_FETCH;
            S_MEMWRITE: begin
                if (mem_ready) begin
                    state_next = S_FETCH;
                end else if (timeout) begin
                    state_next = S_TRAP;
                    cause_next = CAUSE_BUS;
                end
            end
            S_EXECR:   state_next = S_ALUWB;
            S_EXECI:   state_next = S_ALUWB;
            S_ALUWB:   state_next = S_FETCH;
            S_BEQ:     state_next = S_FETCH;
            // JAL redirects the PC here, then ALUWB writes oldPC+4 to rd.
            S_JAL:     state_next = S_ALUWB;
            S_TRAP: begin
                if (trap_clear) begin
                    state_next = S_FETCH;
                    cause_next = CAUSE_NONE;
                end
            end
            default: begin
                state_next = S_FETCH;
                cause_next = CAUSE_NONE;
            end
        endcase
    end

    // Output decode.
    always_comb begin
        pc_write   = 1'b0;
        adr_src    = ADR_PC;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        result_src = RES_ALUOUT;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_RS2;
        alu_op     = ALUOP_ADD;
        reg_write  = 1'b0;
        trap       = 1'b0;
        case (state)
            S_FETCH: begin
                mem_read   = 1'b1;
                adr_src    = ADR_PC;
                alu_src_a  = SRCA_PC;
                alu_src_b  = SRCB_FOUR;
                alu_op     = ALUOP_ADD;
                result_src = RES_ALURESULT;
                pc_write   = mem_ready;
                ir_write   = mem_ready;
            end
            S_DECODE: begin
                // Branch target oldPC+imm lands in ALUOut for BEQ.
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_ADD;
            end
            S_MEMADR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_ADD;
            end
            S_MEMREAD: begin
                mem_read = 1'b1;
                adr_src  = ADR_ALUOUT;
            end
            S_MEMWB: begin
                result_src = RES_RDATA;
                reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                mem_write = 1'b1;
                adr_src   = ADR_ALUOUT;
            end
            S_EXECR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_RS2;
                alu_op    = ALUOP_FUNCT;
            end
            S_EXECI: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                result_src = RES_ALUOUT;
                reg_write  = 1'b1;
            end
            S_BEQ: begin
                alu_src_a  = SRCA_RS1;
                alu_src_b  = SRCB_RS2;
                alu_op     = ALUOP_SUB;
                result_src = RES_ALUOUT;
                pc_write   = zero;
            end
            S_JAL: begin
                alu_src_a  = SRCA_OLDPC;
                alu_src_b  = SRCB_FOUR;
                alu_op     = ALUOP_ADD;
                result_src = RES_ALUOUT;
                pc_write   = 1'b1;
            end
            S_TRAP: begin
                trap = 1'b1;
            end
            default: begin
                trap = 1'b0;
            end
        endcase
    end

    assign trap_cause = cause_q;
    assign state_dbg  = state;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control with WAIT_LIMIT=4.
// Inputs change 1 time unit after the rising edge; outputs are checked shortly after.
// Expected values are hand-derived from the state/output table.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       trap_clear;
    logic       pc_write, adr_src, mem_read, mem_write, ir_write, reg_write, trap;
    logic [1:0] result_src, alu_src_a, alu_src_b, alu_op, trap_cause;
    logic [3:0] state_dbg;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    multicycle_control #(.WAIT_LIMIT(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .trap_clear (trap_clear),
        .pc_write   (pc_write),
        .adr_src    (adr_src),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .result_src (result_src),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .reg_write  (reg_write),
        .trap       (trap),
        .trap_cause (trap_cause),
        .state_dbg  (state_dbg)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n      = 1'b0;
        opcode     = 7'b0110011;
        zero       = 1'b0;
        mem_ready  = 1'b0;
        trap_clear = 1'b0;

        // Reset: FETCH decode, gated by mem_ready.
        #2;
        chk("rst_state", state_dbg, 0);
        chk("rst_pcw_nordy", pc_write, 0);
        chk("rst_irw_nordy", ir_write, 0);
        chk("rst_memrd", mem_read, 1);
        chk("rst_cause", trap_cause, 0);
        chk("rst_trap", trap, 0);
        mem_ready = 1'b1;
        #1;
        chk("rst_pcw_rdy", pc_write, 1);
        chk("rst_irw_rdy", ir_write, 1);
        chk("rst_res", result_src, 2);
        chk("rst_srcb", alu_src_b, 2);
        #1 rst_n = 1'b1;

        // R-type: 0,1,6,8,0
        cyc; chk("r_dec", state_dbg, 1);
        chk("r_dec_a", alu_src_a, 1);
        chk("r_dec_b", alu_src_b, 1);
        chk("r_dec_pcw", pc_write, 0);
        cyc; chk("r_exec", state_dbg, 6);
        chk("r_exec_op", alu_op, 2);
        chk("r_exec_a", alu_src_a, 2);
        chk("r_exec_b", alu_src_b, 0);
        chk("r_exec_rw", reg_write, 0);
        cyc; chk("r_wb", state_dbg, 8);
        chk("r_wb_rw", reg_write, 1);
        chk("r_wb_res", result_src, 0);
        cyc; chk("r_fetch", state_dbg, 0);
        chk("r_fetch_rw", reg_write, 0);

        // lw with MEMREAD stalled 3 cycles (4th stalled cycle would time out).
        opcode = 7'b0000011;
        cyc; chk("lw_dec", state_dbg, 1);
        cyc; chk("lw_adr", state_dbg, 2);
        chk("lw_adr_a", alu_src_a, 2);
        chk("lw_adr_b", alu_src_b, 1);
        cyc; mem_ready = 1'b0; #1;
        chk("lw_rd1", state_dbg, 3);
        chk("lw_rd_mr", mem_read, 1);
        chk("lw_rd_as", adr_src, 1);
        cyc; chk("lw_rd2", state_dbg, 3);
        cyc; chk("lw_rd3", state_dbg, 3);
        cyc; mem_ready = 1'b1; #1;
        chk("lw_rd4", state_dbg, 3);
        chk("lw_rd4_trap", trap, 0);
        cyc; chk("lw_wb", state_dbg, 4);
        chk("lw_wb_res", result_src, 1);
        chk("lw_wb_rw", reg_write, 1);
        cyc; chk("lw_fetch", state_dbg, 0);

        // sw: 0,1,2,5,0
        opcode = 7'b0100011;
        cyc; chk("sw_dec", state_dbg, 1);
        cyc; chk("sw_adr", state_dbg, 2);
        cyc; chk("sw_wr", state_dbg, 5);
        chk("sw_mw", mem_write, 1);
        chk("sw_as", adr_src, 1);
        chk("sw_mr", mem_read, 0);
        cyc; chk("sw_fetch", state_dbg, 0);

        // beq taken then not taken.
        opcode = 7'b1100011;
        zero   = 1'b1;
        cyc; chk("beq1_dec", state_dbg, 1);
        cyc; chk("beq1_st", state_dbg, 9);
        chk("beq1_pcw", pc_write, 1);
        chk("beq1_op", alu_op, 1);
        chk("beq1_a", alu_src_a, 2);
        cyc; chk("beq1_fetch", state_dbg, 0);
        zero = 1'b0;
        cyc; chk("beq0_dec", state_dbg, 1);
        cyc; chk("beq0_st", state_dbg, 9);
        chk("beq0_pcw", pc_write, 0);
        chk("beq0_op", alu_op, 1);
        cyc; chk("beq0_fetch", state_dbg, 0);

        // jal: 0,1,10,8,0
        opcode = 7'b1101111;
        cyc; chk("jal_dec", state_dbg, 1);
        cyc; chk("jal_st", state_dbg, 10);
        chk("jal_pcw", pc_write, 1);
        chk("jal_a", alu_src_a, 1);
        chk("jal_b", alu_src_b, 2);
        cyc; chk("jal_wb", state_dbg, 8);
        chk("jal_wb_rw", reg_write, 1);
        cyc; chk("jal_fetch", state_dbg, 0);

        // Illegal opcode; trap_clear asserted in FETCH must be ignored.
        opcode     = 7'b1111111;
        trap_clear = 1'b1;
        cyc; chk("ill_dec", state_dbg, 1);
        trap_clear = 1'b0;
        cyc; chk("ill_trap", state_dbg, 11);
        chk("ill_trap_o", trap, 1);
        chk("ill_cause", trap_cause, 1);
        chk("ill_memrd", mem_read, 0);
        chk("ill_pcw", pc_write, 0);
        cyc; chk("ill_hold", state_dbg, 11);
        chk("ill_hold_cause", trap_cause, 1);
        trap_clear = 1'b1;
        cyc; chk("ill_clr", state_dbg, 0);
        chk("ill_clr_cause", trap_cause, 0);
        chk("ill_clr_trap", trap, 0);
        trap_clear = 1'b0;

        // Fetch timeout: 4 stalled cycles, TRAP on the 5th.
        opcode    = 7'b0110011;
        mem_ready = 1'b0;
        #1;
        chk("to_pcw", pc_write, 0);
        cyc;
        cyc;
        cyc; chk("to_c4", state_dbg, 0);
        cyc; chk("to_trap", state_dbg, 11);
        chk("to_cause", trap_cause, 2);
        chk("to_memrd", mem_read, 0);
        trap_clear = 1'b1;
        cyc; chk("to_clr", state_dbg, 0);
        chk("to_clr_cause", trap_cause, 0);
        trap_clear = 1'b0;

        // Same stall, but ready arrives on the 4th cycle: normal progress.
        cyc;
        cyc;
        cyc; mem_ready = 1'b1; #1;
        chk("rdy4_state", state_dbg, 0);
        chk("rdy4_pcw", pc_write, 1);
        cyc; chk("rdy4_dec", state_dbg, 1);
        chk("rdy4_trap", trap, 0);
        chk("rdy4_cause", trap_cause, 0);
        cyc; chk("rdy4_exec", state_dbg, 6);
        cyc; chk("rdy4_wb", state_dbg, 8);
        cyc; chk("rdy4_fetch", state_dbg, 0);

        // Async reset in the middle of EXECI.
        opcode = 7'b0010011;
        cyc; chk("ai_dec", state_dbg, 1);
        cyc; chk("ai_exec", state_dbg, 7);
        chk("ai_exec_op", alu_op, 2);
        chk("ai_exec_b", alu_src_b, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_state", state_dbg, 0);
        chk("ar_rw", reg_write, 0);
        chk("ar_pcw", pc_write, 1);
        mem_ready = 1'b0;
        #1 rst_n = 1'b1;
        // Counter restarted from 0: TRAP exactly after 4 stalled cycles.
        cyc;
        cyc;
        cyc; chk("ar_c4", state_dbg, 0);
        cyc; chk("ar_trap", state_dbg, 11);
        chk("ar_cause", trap_cause, 2);
        trap_clear = 1'b1;
        mem_ready  = 1'b1;
        cyc; chk("ar_clr", state_dbg, 0);
        trap_clear = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
